// File: rtl/mac_sequencer.sv
// Purpose : control sequencer for a pipelined multiply-accumulate datapath (new_sum / weight address / zero mask / out_vld).
// Latency : control outputs combinational with the accepted beat; out_vld/out_ch ACC_LAT cycles after a channel's last beat.
// Backpressure: in_rdy high only in RUN; stalls (in_vld low) hold the counters and force w_zero so the sum is unchanged.
module mac_sequencer #(
    parameter  int NUM_CYC = 32,
    parameter  int NUM_OUT = 4,
    parameter  int ACC_LAT = 6,
    localparam int CYC_W   = ($clog2(NUM_CYC) < 1) ? 1 : $clog2(NUM_CYC),
    localparam int CH_W    = ($clog2(NUM_OUT) < 1) ? 1 : $clog2(NUM_OUT),
    localparam int ADDR_W  = ($clog2(NUM_CYC * NUM_OUT) < 1) ? 1 : $clog2(NUM_CYC * NUM_OUT)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic              i_in_vld,
    output logic              o_in_rdy,
    output logic              o_new_sum,
    output logic              o_w_zero,
    output logic [ADDR_W-1:0] o_w_addr,
    output logic              o_out_vld,
    output logic [CH_W-1:0]   o_out_ch,
    output logic              o_frame_done,
    output logic              o_busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CYC_W-1:0]  r_cyc;
    logic [CH_W-1:0]   r_ch;
    logic [ACC_LAT-1:0] r_sr_vld;
    logic [CH_W-1:0]   r_sr_ch [ACC_LAT];

    logic              w_accept;
    logic              w_last_beat;
    logic              w_last_ch;
    logic [ACC_LAT-1:0] w_sr_rest;

    assign w_accept    = i_in_vld & (r_state == ST_RUN);
    assign w_last_beat = (r_cyc == CYC_W'(NUM_CYC - 1));
    assign w_last_ch   = (r_ch == CH_W'(NUM_OUT - 1));

    // Pending markers other than the one currently presented at the output stage.
    always_comb begin
        w_sr_rest            = r_sr_vld;
        w_sr_rest[ACC_LAT-1] = 1'b0;
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: leave DRAIN once the sum now at the output is the last one in flight.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (i_start) w_state_nxt = ST_RUN;
            ST_RUN:   if (w_accept && w_last_beat && w_last_ch) w_state_nxt = ST_DRAIN;
            ST_DRAIN: if (w_sr_rest == '0) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Beat and channel counters; they only move on an accepted beat and wrap to 0 at frame end.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cyc <= '0;
            r_ch  <= '0;
        end else if (w_accept) begin
            if (w_last_beat) begin
                r_cyc <= '0;
                r_ch  <= w_last_ch ? '0 : r_ch + CH_W'(1);
            end else begin
                r_cyc <= r_cyc + CYC_W'(1);
            end
        end
    end

    // Latency tracker: a channel-end marker enters on its last beat and emerges ACC_LAT cycles later.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_sr_vld <= '0;
            for (int i = 0; i < ACC_LAT; i++) r_sr_ch[i] <= '0;
        end else begin
            r_sr_vld[0] <= w_accept & w_last_beat;
            r_sr_ch[0]  <= r_ch;
            for (int i = 1; i < ACC_LAT; i++) begin
                r_sr_vld[i] <= r_sr_vld[i-1];
                r_sr_ch[i]  <= r_sr_ch[i-1];
            end
        end
    end

    assign o_in_rdy     = (r_state == ST_RUN);
    assign o_new_sum    = w_accept & (r_cyc == '0);
    assign o_w_zero     = ~w_accept;
    assign o_w_addr     = ADDR_W'(r_ch * NUM_CYC + r_cyc);
    assign o_out_vld    = r_sr_vld[ACC_LAT-1];
    assign o_out_ch     = r_sr_ch[ACC_LAT-1];
    assign o_frame_done = o_out_vld & (o_out_ch == CH_W'(NUM_OUT - 1));
    assign o_busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_mac_sequencer.sv
module tb_mac_sequencer;

    localparam int NC  = 32;
    localparam int NO  = 4;
    localparam int LAT = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // main instance
    logic       rst_n, start, in_vld;
    logic       a_in_rdy, a_new_sum, a_w_zero, a_out_vld, a_frame_done, a_busy;
    logic [6:0] a_w_addr;
    logic [1:0] a_out_ch;

    // minimal instance: NUM_OUT=1, NUM_CYC=2, ACC_LAT=1
    logic       b_rst_n, b_start, b_in_vld;
    logic       b_in_rdy, b_new_sum, b_w_zero, b_out_vld, b_frame_done, b_busy;
    logic [0:0] b_w_addr;
    logic [0:0] b_out_ch;

    mac_sequencer #(.NUM_CYC(NC), .NUM_OUT(NO), .ACC_LAT(LAT)) u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_in_vld(in_vld),
        .o_in_rdy(a_in_rdy), .o_new_sum(a_new_sum), .o_w_zero(a_w_zero),
        .o_w_addr(a_w_addr), .o_out_vld(a_out_vld), .o_out_ch(a_out_ch),
        .o_frame_done(a_frame_done), .o_busy(a_busy)
    );

    mac_sequencer #(.NUM_CYC(2), .NUM_OUT(1), .ACC_LAT(1)) u_small (
        .i_clk(clk), .i_rst_n(b_rst_n), .i_start(b_start), .i_in_vld(b_in_vld),
        .o_in_rdy(b_in_rdy), .o_new_sum(b_new_sum), .o_w_zero(b_w_zero),
        .o_w_addr(b_w_addr), .o_out_vld(b_out_vld), .o_out_ch(b_out_ch),
        .o_frame_done(b_frame_done), .o_busy(b_busy)
    );

    int total = 0;
    int bad   = 0;
    int cyc_n = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %0d want %0d", name, cyc_n, act, exp);
        end
    endtask

    // ---------------- frame-level model ----------------
    bit m_run  = 1'b0;   // sequencer is taking beats
    bit m_busy = 1'b0;   // frame in progress (run or drain)
    int m_k    = 0;      // beats accepted so far in this frame
    int q_due[$];        // cycle at which each finished sum is due
    int q_ch[$];

    // ---------------- observation log for literal checks ----------------
    int first_acc, acc_cnt, last_addr, fd_rel, busy_fall;
    bit busy_seen;
    int ns_list[$];
    int out_rel[$];
    int out_chq[$];

    task automatic clear_log();
        first_acc = -1; acc_cnt = 0; last_addr = -1; fd_rel = -1; busy_fall = -1;
        busy_seen = 1'b0;
        ns_list.delete(); out_rel.delete(); out_chq.delete();
    endtask

    // Compare DUT against the model every cycle, then advance the model.
    always @(negedge clk) begin
        bit m_acc, e_out, was_busy;
        int e_ch;
        if (chk_en) begin
            m_acc = in_vld && m_run;
            e_out = (q_due.size() > 0) && (q_due[0] == cyc_n);
            e_ch  = e_out ? q_ch[0] : 0;
            check("in_rdy",  a_in_rdy,  m_run);
            check("new_sum", a_new_sum, m_acc && (m_k % NC == 0));
            check("w_zero",  a_w_zero,  !m_acc);
            check("w_addr",  a_w_addr,  m_k);
            check("out_vld", a_out_vld, e_out);
            if (e_out) check("out_ch", a_out_ch, e_ch);
            check("frame_done", a_frame_done, e_out && (e_ch == NO - 1));
            check("busy", a_busy, m_busy);

            if (in_vld && a_in_rdy) begin
                if (first_acc < 0) first_acc = cyc_n;
                if (a_new_sum) ns_list.push_back(acc_cnt);
                last_addr = a_w_addr;
                acc_cnt++;
            end
            if (a_out_vld) begin
                out_rel.push_back(cyc_n - first_acc);
                out_chq.push_back(a_out_ch);
            end
            if (a_frame_done) fd_rel = cyc_n - first_acc;
            if (a_busy) busy_seen = 1'b1;
            else if (busy_seen && busy_fall < 0) busy_fall = cyc_n - first_acc;

            was_busy = m_busy;
            if (!rst_n) begin
                m_run = 1'b0; m_busy = 1'b0; m_k = 0;
                q_due.delete(); q_ch.delete();
            end else begin
                if (e_out) begin
                    void'(q_due.pop_front());
                    void'(q_ch.pop_front());
                    if (e_ch == NO - 1) m_busy = 1'b0;
                end
                if (m_acc) begin
                    if (m_k % NC == NC - 1) begin
                        q_due.push_back(cyc_n + LAT);
                        q_ch.push_back(m_k / NC);
                    end
                    m_k++;
                    if (m_k == NC * NO) begin
                        m_k = 0;
                        m_run = 1'b0;
                    end
                end
                if (!was_busy && start) begin
                    m_busy = 1'b1;
                    m_run  = 1'b1;
                end
            end
        end
        cyc_n++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (a_busy !== 1'b0 && n < 1000) begin
            step();
            n++;
        end
        if (n >= 1000) check("wait_idle timeout", 1, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    int exp_rel1 [4] = '{37, 69, 101, 133};
    int exp_rel2 [4] = '{68, 132, 196, 260};

    initial begin
        rst_n = 1'b0; start = 1'b0; in_vld = 1'b0;
        b_rst_n = 1'b0; b_start = 1'b0; b_in_vld = 1'b0;
        clear_log();
        step();
        chk_en = 1'b1;
        @(negedge clk);
        #1;
        check("rst w_zero",  a_w_zero, 1);
        check("rst busy",    a_busy, 0);
        check("rst in_rdy",  a_in_rdy, 0);
        check("rst out_vld", a_out_vld, 0);
        check("rst w_addr",  a_w_addr, 0);
        step();
        rst_n = 1'b1;
        step();

        // 1: continuous stream
        clear_log();
        start = 1'b1; in_vld = 1'b1;
        step();
        start = 1'b0;
        wait_idle();
        in_vld = 1'b0;
        step();
        check("t1 new_sum count", ns_list.size(), 4);
        for (int i = 0; i < 4 && i < ns_list.size(); i++) check("t1 new_sum idx", ns_list[i], 32 * i);
        check("t1 out count", out_rel.size(), 4);
        for (int i = 0; i < 4 && i < out_rel.size(); i++) begin
            check("t1 out time", out_rel[i], exp_rel1[i]);
            check("t1 out ch", out_chq[i], i);
        end
        check("t1 frame_done time", fd_rel, 133);
        check("t1 busy fall", busy_fall, 134);
        check("t1 last addr", last_addr, 127);

        // 2: alternating valid
        clear_log();
        start = 1'b1; in_vld = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 1000 && a_busy; i++) begin
            in_vld = (i % 2 == 0);
            step();
        end
        in_vld = 1'b0;
        check("t2 busy after run", a_busy, 0);
        step();
        check("t2 out count", out_rel.size(), 4);
        for (int i = 0; i < 4 && i < out_rel.size(); i++) check("t2 out time", out_rel[i], exp_rel2[i]);
        check("t2 accepts", acc_cnt, 128);

        // 3: start during RUN and DRAIN ignored, restart from IDLE
        clear_log();
        start = 1'b1; in_vld = 1'b1;
        step();
        start = 1'b0;
        repeat (49) step();
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (80) step();
        check("t3 in drain", a_busy && !a_in_rdy, 1);
        start = 1'b1;
        step();
        start = 1'b0;
        wait_idle();
        start = 1'b1;
        step();
        start = 1'b0;
        wait_idle();
        in_vld = 1'b0;
        step();
        check("t3 accepts", acc_cnt, 256);
        check("t3 out count", out_rel.size(), 8);
        check("t3 new_sum count", ns_list.size(), 8);
        if (ns_list.size() > 4) check("t3 second frame first", ns_list[4], 128);
        for (int i = 0; i < 8 && i < out_chq.size(); i++) check("t3 out ch", out_chq[i], i % 4);

        // 4: reset at accept 40
        clear_log();
        start = 1'b1; in_vld = 1'b1;
        step();
        start = 1'b0;
        repeat (40) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("t4 busy after rst", a_busy, 0);
        check("t4 out_vld after rst", a_out_vld, 0);
        repeat (60) step();
        in_vld = 1'b0;
        check("t4 accepts", acc_cnt, 41);
        check("t4 out count", out_rel.size(), 1);
        if (out_chq.size() > 0) check("t4 out ch", out_chq[0], 0);
        check("t4 no frame_done", fd_rel, -1);

        // 5: minimal configuration
        step();
        step();
        b_rst_n = 1'b1; b_start = 1'b1;
        step();
        b_start = 1'b0; b_in_vld = 1'b1;
        @(negedge clk);
        check("t5 beat0 new_sum", b_new_sum, 1);
        check("t5 beat0 addr", b_w_addr, 0);
        check("t5 beat0 w_zero", b_w_zero, 0);
        step();
        @(negedge clk);
        check("t5 beat1 new_sum", b_new_sum, 0);
        check("t5 beat1 addr", b_w_addr, 1);
        check("t5 beat1 out_vld", b_out_vld, 0);
        step();
        b_in_vld = 1'b0;
        @(negedge clk);
        check("t5 out_vld", b_out_vld, 1);
        check("t5 frame_done", b_frame_done, 1);
        check("t5 out_ch", b_out_ch, 0);
        check("t5 busy drain", b_busy, 1);
        check("t5 in_rdy drain", b_in_rdy, 0);
        step();
        @(negedge clk);
        check("t5 busy idle", b_busy, 0);
        check("t5 out_vld idle", b_out_vld, 0);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
